// File: rtl/debug_insn_injector_pkg.sv
// Shared types, RV32 encoding constants and field-packing helpers for the debug instruction injector.
package debug_insn_injector_pkg;

    typedef enum logic [1:0] {
        CMD_REG_READ  = 2'd0,
        CMD_REG_WRITE = 2'd1,
        CMD_MEM_READ  = 2'd2,
        CMD_MEM_WRITE = 2'd3
    } dbg_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_ISSUE,
        ST_WAIT_RET,
        ST_RESP
    } inj_state_t;

    localparam int STEP_W = 3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] CSRRW_F3 = 3'b001;
    localparam logic [2:0] CSRRS_F3 = 3'b010;
    localparam logic [2:0] LW_F3    = 3'b010;
    localparam logic [2:0] SW_F3    = 3'b010;

    localparam logic [4:0] GPR_X0 = 5'd0;
    localparam logic [4:0] GPR_X8 = 5'd8;
    localparam logic [4:0] GPR_X9 = 5'd9;

    // addi x0,x0,0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_csr(input logic [11:0] csr, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, OPC_SYSTEM};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm20);
        return {imm20, rd, OPC_LUI};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm12);
        return {imm12, rs1, LW_F3, rd, OPC_LOAD};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [11:0] imm12);
        return {imm12[11:5], rs2, rs1, SW_F3, imm12[4:0], OPC_STORE};
    endfunction

endpackage

// File: rtl/debug_insn_injector_encoder.sv
// Combinational step table: maps (command, step) to the instruction word, the last-step flag
// and where to jump if that step faults.
module debug_insn_encoder import debug_insn_injector_pkg::*; #(
    parameter logic [11:0] SCRATCH0_CSR = 12'h7B2,
    parameter logic [11:0] SCRATCH1_CSR = 12'h7B3
) (
    input  logic [1:0]        cmd_type,
    input  logic [STEP_W-1:0] step,
    input  logic [4:0]        regno,
    input  logic [19:0]       hi,
    input  logic [11:0]       lo,
    output logic [31:0]       insn,
    output logic              last_step,
    output logic [STEP_W-1:0] cleanup_step,
    output logic              cleanup_resp
);

    always_comb begin
        insn         = INSN_NOP;
        last_step    = 1'b0;
        cleanup_step = '0;
        cleanup_resp = 1'b1;
        case (dbg_cmd_t'(cmd_type))
            CMD_REG_READ: begin
                insn      = enc_csr(SCRATCH0_CSR, regno, CSRRW_F3, GPR_X0);
                last_step = 1'b1;
            end
            CMD_REG_WRITE: begin
                insn      = enc_csr(SCRATCH0_CSR, GPR_X0, CSRRS_F3, regno);
                last_step = 1'b1;
            end
            CMD_MEM_READ: begin
                case (step)
                    3'd0:    insn = enc_csr(SCRATCH1_CSR, GPR_X8, CSRRW_F3, GPR_X0);
                    3'd1:    insn = enc_lui(GPR_X8, hi);
                    3'd2:    insn = enc_lw(GPR_X8, GPR_X8, lo);
                    3'd3:    insn = enc_csr(SCRATCH0_CSR, GPR_X8, CSRRW_F3, GPR_X0);
                    default: insn = enc_csr(SCRATCH1_CSR, GPR_X0, CSRRS_F3, GPR_X8);
                endcase
                last_step = (step >= 3'd4);
                // Once x8 has been saved, any fault must still restore it from dscratch1
                if (step == 3'd1 || step == 3'd2 || step == 3'd3) begin
                    cleanup_step = 3'd4;
                    cleanup_resp = 1'b0;
                end
            end
            CMD_MEM_WRITE: begin
                case (step)
                    3'd0:    insn = enc_csr(SCRATCH1_CSR, GPR_X8, CSRRW_F3, GPR_X0);
                    3'd1:    insn = enc_lui(GPR_X8, hi);
                    3'd2:    insn = enc_csr(SCRATCH0_CSR, GPR_X9, CSRRW_F3, GPR_X9);
                    3'd3:    insn = enc_sw(GPR_X9, GPR_X8, lo);
                    3'd4:    insn = enc_csr(SCRATCH0_CSR, GPR_X9, CSRRW_F3, GPR_X9);
                    default: insn = enc_csr(SCRATCH1_CSR, GPR_X0, CSRRS_F3, GPR_X8);
                endcase
                last_step = (step >= 3'd5);
                // x9 only needs swapping back if the swap at step 2 actually committed
                if (step == 3'd1 || step == 3'd2) begin
                    cleanup_step = 3'd5;
                    cleanup_resp = 1'b0;
                end else if (step == 3'd3) begin
                    cleanup_step = 3'd4;
                    cleanup_resp = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/debug_insn_injector.sv
// Debug instruction injector: sequences abstract debug commands into RV32 instructions fed to a
// halted core one at a time, with data exchanged through the dscratch CSRs.
module debug_insn_injector import debug_insn_injector_pkg::*; #(
    parameter logic [11:0] SCRATCH0_CSR   = 12'h7B2,
    parameter logic [11:0] SCRATCH1_CSR   = 12'h7B3,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [4:0]  cmd_regno_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        insn_valid_o,
    input  logic        insn_ready_i,
    output logic [31:0] insn_o,
    input  logic        insn_retired_i,
    input  logic        insn_exc_i,
    output logic        scratch_we_o,
    output logic [31:0] scratch_wdata_o,
    input  logic [31:0] scratch0_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_error_o
);

    localparam int TIMER_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    inj_state_t        state;
    dbg_cmd_t          cmd_type_q;
    logic [4:0]        regno_q;
    logic [31:0]       addr_q;
    logic [STEP_W-1:0] step;
    logic [TIMER_W-1:0] timer;
    logic              err;

    logic [19:0]       hi;
    logic [11:0]       lo;
    logic [31:0]       enc_insn;
    logic              last_step;
    logic [STEP_W-1:0] cleanup_step;
    logic              cleanup_resp;
    logic              fault;
    logic              read_cmd;

    // lw/sw sign-extend lo, so hi is pre-incremented when bit 11 is set
    assign hi = addr_q[31:12] + {19'd0, addr_q[11]};
    assign lo = addr_q[11:0];

    assign fault    = insn_exc_i || (timer == TIMER_LAST);
    assign read_cmd = (cmd_type_q == CMD_REG_READ) || (cmd_type_q == CMD_MEM_READ);
    assign insn_o   = insn_valid_o ? enc_insn : INSN_NOP;

    debug_insn_encoder #(
        .SCRATCH0_CSR(SCRATCH0_CSR),
        .SCRATCH1_CSR(SCRATCH1_CSR)
    ) u_encoder (
        .cmd_type     (cmd_type_q),
        .step         (step),
        .regno        (regno_q),
        .hi           (hi),
        .lo           (lo),
        .insn         (enc_insn),
        .last_step    (last_step),
        .cleanup_step (cleanup_step),
        .cleanup_resp (cleanup_resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cmd_type_q      <= CMD_REG_READ;
            regno_q         <= '0;
            addr_q          <= '0;
            scratch_wdata_o <= '0;
            step            <= '0;
            timer           <= '0;
            err             <= 1'b0;
            cmd_ready_o     <= 1'b1;
            insn_valid_o    <= 1'b0;
            scratch_we_o    <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_error_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_type_q      <= dbg_cmd_t'(cmd_type_i);
                        regno_q         <= cmd_regno_i;
                        addr_q          <= cmd_addr_i;
                        scratch_wdata_o <= cmd_data_i;
                        err             <= 1'b0;
                        step            <= '0;
                        cmd_ready_o     <= 1'b0;
                        if (dbg_cmd_t'(cmd_type_i) == CMD_REG_WRITE ||
                            dbg_cmd_t'(cmd_type_i) == CMD_MEM_WRITE) begin
                            scratch_we_o <= 1'b1;
                            state        <= ST_PRELOAD;
                        end else begin
                            insn_valid_o <= 1'b1;
                            state        <= ST_ISSUE;
                        end
                    end
                end
                ST_PRELOAD: begin
                    scratch_we_o <= 1'b0;
                    insn_valid_o <= 1'b1;
                    state        <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (insn_ready_i) begin
                        insn_valid_o <= 1'b0;
                        timer        <= '0;
                        state        <= ST_WAIT_RET;
                    end
                end
                ST_WAIT_RET: begin
                    // An exception in the same cycle as retire takes priority
                    if (fault) begin
                        err <= 1'b1;
                        if (cleanup_resp) begin
                            state <= ST_RESP;
                        end else begin
                            step         <= cleanup_step;
                            insn_valid_o <= 1'b1;
                            state        <= ST_ISSUE;
                        end
                    end else if (insn_retired_i) begin
                        if (last_step) begin
                            state <= ST_RESP;
                        end else begin
                            step         <= step + STEP_W'(1);
                            insn_valid_o <= 1'b1;
                            state        <= ST_ISSUE;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_RESP: begin
                    // First RESP cycle samples dscratch0 after the final CSR write has landed
                    if (!rsp_valid_o) begin
                        rsp_valid_o <= 1'b1;
                        rsp_error_o <= err;
                        rsp_data_o  <= (read_cmd && !err) ? scratch0_i : 32'd0;
                    end else if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_error_o <= 1'b0;
                        rsp_data_o  <= '0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    insn_valid_o <= 1'b0;
                    scratch_we_o <= 1'b0;
                    rsp_valid_o  <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_insn_injector.sv
// Bench for debug_insn_injector: acts as the halted core, scoreboarding every injected instruction
// and the final response against independently encoded expectations.
module tb_debug_insn_injector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_type_i = 2'd0;
    logic [4:0]  cmd_regno_i = 5'd0;
    logic [31:0] cmd_addr_i = 32'd0;
    logic [31:0] cmd_data_i = 32'd0;
    logic        insn_valid_o;
    logic        insn_ready_i = 1'b0;
    logic [31:0] insn_o;
    logic        insn_retired_i = 1'b0;
    logic        insn_exc_i = 1'b0;
    logic        scratch_we_o;
    logic [31:0] scratch_wdata_o;
    logic [31:0] scratch0_i = 32'h0BAD_0000;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;

    typedef struct {
        logic [31:0] insn;
        bit          s0_we;
        logic [31:0] s0_val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TMO = 1024;

    debug_insn_injector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_type_i      (cmd_type_i),
        .cmd_regno_i     (cmd_regno_i),
        .cmd_addr_i      (cmd_addr_i),
        .cmd_data_i      (cmd_data_i),
        .insn_valid_o    (insn_valid_o),
        .insn_ready_i    (insn_ready_i),
        .insn_o          (insn_o),
        .insn_retired_i  (insn_retired_i),
        .insn_exc_i      (insn_exc_i),
        .scratch_we_o    (scratch_we_o),
        .scratch_wdata_o (scratch_wdata_o),
        .scratch0_i      (scratch0_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_data_o      (rsp_data_o),
        .rsp_error_o     (rsp_error_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] b_csr(input logic [11:0] csr, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'h73};
    endfunction

    function automatic logic [31:0] b_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction

    function automatic logic [31:0] b_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] b_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic void push(input logic [31:0] insn, input bit we, input logic [31:0] val);
        exp_t e;
        e.insn   = insn;
        e.s0_we  = we;
        e.s0_val = val;
        exp_q.push_back(e);
    endfunction

    task automatic start_cmd(input logic [1:0] t, input logic [4:0] r, input logic [31:0] a,
                             input logic [31:0] d);
        cmd_type_i  = t;
        cmd_regno_i = r;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        cmd_valid_i = 1'b1;
    endtask

    // Core model: accepts instructions, retires/faults/hangs them, and handles the response.
    task automatic serve(input int exc_at, input int hang_at, input int abort_at,
                         input int ready_delay, input int rsp_delay,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_we);
        int          cyc = 0;
        int          idx = 0;
        int          stall = 0;
        int          we_cnt = 0;
        int          hang_cnt = 0;
        int          bad_stall = 0;
        int          rsp_drop = 0;
        bit          waiting = 0;
        bit          first = 1;
        bit          s0_pend = 0;
        bit          aborted = 0;
        logic [31:0] s0_next = '0;
        logic [31:0] held = '0;
        exp_t        e;
        e.insn = '0; e.s0_we = 0; e.s0_val = '0;
        while (cyc < 4000) begin
            @(posedge clk); #1; cyc++;
            insn_ready_i   = 1'b0;
            insn_retired_i = 1'b0;
            insn_exc_i     = 1'b0;
            if (s0_pend) begin
                scratch0_i = s0_next;
                s0_pend    = 0;
            end
            if (first) begin
                first = 0;
                cmd_valid_i = 1'b0;
                vectors++;
                if (cmd_ready_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL cmd_ready_busy: got %b expected 0", cmd_ready_o);
                end
            end
            if (scratch_we_o === 1'b1) begin
                we_cnt++;
                vectors++;
                if (scratch_wdata_o !== cmd_data_i) begin
                    miscompares++;
                    $display("[TB] FAIL scratch_wdata: got %h expected %h", scratch_wdata_o, cmd_data_i);
                end
                s0_pend = 1;
                s0_next = scratch_wdata_o;
            end
            if (rsp_valid_o === 1'b1) break;
            if (insn_valid_o === 1'b1) begin
                waiting = 0;
                if (idx == 0 && stall < ready_delay) begin
                    if (stall == 0) held = insn_o;
                    else if (insn_o !== held) bad_stall++;
                    stall++;
                end else begin
                    if (idx == 0 && stall > 0 && insn_o !== held) bad_stall++;
                    insn_ready_i = 1'b1;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL insn_extra: got %h expected none", insn_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (insn_o !== e.insn) begin
                            miscompares++;
                            $display("[TB] FAIL insn_step%0d: got %h expected %h", idx, insn_o, e.insn);
                        end
                    end
                    waiting = 1;
                    idx++;
                end
            end else if (waiting) begin
                if (idx - 1 == abort_at) begin
                    rst_n   = 1'b0;
                    aborted = 1;
                    break;
                end else if (idx - 1 == exc_at) begin
                    insn_exc_i = 1'b1;
                    waiting    = 0;
                end else if (idx - 1 == hang_at) begin
                    hang_cnt++;
                end else begin
                    insn_retired_i = 1'b1;
                    waiting        = 0;
                    if (e.s0_we) begin
                        s0_pend = 1;
                        s0_next = e.s0_val;
                    end
                end
            end
        end
        insn_ready_i   = 1'b0;
        insn_retired_i = 1'b0;
        insn_exc_i     = 1'b0;
        if (aborted) return;
        vectors++;
        if (rsp_valid_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rsp_timeout: got rsp_valid %b expected 1", rsp_valid_o);
            return;
        end
        vectors++;
        if (rsp_data_o !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL rsp_data: got %h expected %h", rsp_data_o, exp_data);
        end
        vectors++;
        if (rsp_error_o !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL rsp_error: got %b expected %b", rsp_error_o, exp_err);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL insn_missing: got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (we_cnt != exp_we) begin
            miscompares++;
            $display("[TB] FAIL scratch_we_pulses: got %0d expected %0d", we_cnt, exp_we);
        end
        if (ready_delay > 0) begin
            vectors++;
            if (bad_stall != 0 || stall != ready_delay) begin
                miscompares++;
                $display("[TB] FAIL insn_stall: got %0d unstable, %0d stalled expected 0, %0d",
                         bad_stall, stall, ready_delay);
            end
        end
        if (hang_at >= 0) begin
            vectors++;
            if (hang_cnt < TMO || hang_cnt > TMO + 2) begin
                miscompares++;
                $display("[TB] FAIL timeout_len: got %0d cycles expected %0d..%0d", hang_cnt, TMO, TMO + 2);
            end
        end
        for (int k = 0; k < rsp_delay; k++) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b1) rsp_drop++;
        end
        if (rsp_delay > 0) begin
            vectors++;
            if (rsp_drop != 0) begin
                miscompares++;
                $display("[TB] FAIL rsp_hold: got %0d dropped cycles expected 0", rsp_drop);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        vectors++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL back_to_idle: got ready %b valid %b expected 1 0", cmd_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (cmd_ready_o !== 1'b1 || insn_valid_o !== 1'b0 || scratch_we_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctl: got ready %b ival %b we %b expected 1 0 0",
                     cmd_ready_o, insn_valid_o, scratch_we_o);
        end
        vectors++;
        if (insn_o !== NOP) begin
            miscompares++;
            $display("[TB] FAIL reset_insn: got %h expected %h", insn_o, NOP);
        end
        vectors++;
        if (rsp_valid_o !== 1'b0 || rsp_error_o !== 1'b0 || rsp_data_o !== 32'd0 ||
            scratch_wdata_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp: got v %b e %b d %h w %h expected 0 0 0 0",
                     rsp_valid_o, rsp_error_o, rsp_data_o, scratch_wdata_o);
        end
    endtask

    task automatic test_reg_read();
        push(32'h7B22_9073, 1, 32'hDEAD_BEEF);
        start_cmd(2'd0, 5'd5, 32'd0, 32'd0);
        serve(-1, -1, -1, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    endtask

    task automatic test_reg_write();
        push(32'h7B20_2573, 0, 32'd0);
        start_cmd(2'd1, 5'd10, 32'd0, 32'h0000_1234);
        serve(-1, -1, -1, 0, 0, 32'd0, 1'b0, 1);
    endtask

    task automatic test_mem_read();
        push(b_csr(12'h7B3, 5'd8, 3'b001, 5'd0), 0, 32'd0);
        push(32'h8000_1437, 0, 32'd0);
        push(b_lw(5'd8, 5'd8, 12'hFFC), 0, 32'd0);
        push(b_csr(12'h7B2, 5'd8, 3'b001, 5'd0), 1, 32'hCAFE_F00D);
        push(b_csr(12'h7B3, 5'd0, 3'b010, 5'd8), 0, 32'd0);
        start_cmd(2'd2, 5'd0, 32'h8000_0FFC, 32'd0);
        serve(-1, -1, -1, 0, 0, 32'hCAFE_F00D, 1'b0, 0);
    endtask

    task automatic test_mem_write_exc();
        push(b_csr(12'h7B3, 5'd8, 3'b001, 5'd0), 0, 32'd0);
        push(b_lui(5'd8, 20'h00001), 0, 32'd0);
        push(b_csr(12'h7B2, 5'd9, 3'b001, 5'd9), 0, 32'd0);
        push(b_sw(5'd9, 5'd8, 12'h234), 0, 32'd0);
        push(b_csr(12'h7B2, 5'd9, 3'b001, 5'd9), 0, 32'd0);
        push(b_csr(12'h7B3, 5'd0, 3'b010, 5'd8), 0, 32'd0);
        start_cmd(2'd3, 5'd0, 32'h0000_1234, 32'h0000_55AA);
        serve(3, -1, -1, 0, 0, 32'd0, 1'b1, 1);
    endtask

    task automatic test_mem_write_boundary();
        push(b_csr(12'h7B3, 5'd8, 3'b001, 5'd0), 0, 32'd0);
        push(b_lui(5'd8, 20'hFFFF0), 0, 32'd0);
        push(b_csr(12'h7B2, 5'd9, 3'b001, 5'd9), 0, 32'd0);
        push(b_sw(5'd9, 5'd8, 12'h800), 0, 32'd0);
        push(b_csr(12'h7B2, 5'd9, 3'b001, 5'd9), 0, 32'd0);
        push(b_csr(12'h7B3, 5'd0, 3'b010, 5'd8), 0, 32'd0);
        start_cmd(2'd3, 5'd0, 32'hFFFE_F800, 32'hA5A5_0001);
        serve(-1, -1, -1, 0, 0, 32'd0, 1'b0, 1);
    endtask

    task automatic test_mem_read_exc();
        push(b_csr(12'h7B3, 5'd8, 3'b001, 5'd0), 0, 32'd0);
        push(b_lui(5'd8, 20'h00000), 0, 32'd0);
        push(b_csr(12'h7B3, 5'd0, 3'b010, 5'd8), 0, 32'd0);
        start_cmd(2'd2, 5'd0, 32'h0000_0010, 32'd0);
        serve(1, -1, -1, 0, 0, 32'd0, 1'b1, 0);
    endtask

    task automatic test_ready_stall();
        push(b_csr(12'h7B2, 5'd17, 3'b001, 5'd0), 1, 32'h1357_9BDF);
        start_cmd(2'd0, 5'd17, 32'd0, 32'd0);
        serve(-1, -1, -1, 10, 0, 32'h1357_9BDF, 1'b0, 0);
    endtask

    task automatic test_timeout();
        push(b_csr(12'h7B2, 5'd3, 3'b001, 5'd0), 0, 32'd0);
        start_cmd(2'd0, 5'd3, 32'd0, 32'd0);
        serve(-1, 0, -1, 0, 0, 32'd0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        push(b_csr(12'h7B2, 5'd1, 3'b001, 5'd0), 1, 32'h1111_2222);
        start_cmd(2'd0, 5'd1, 32'd0, 32'd0);
        serve(-1, -1, -1, 0, 3, 32'h1111_2222, 1'b0, 0);
        push(b_csr(12'h7B2, 5'd31, 3'b001, 5'd0), 1, 32'h3333_4444);
        start_cmd(2'd0, 5'd31, 32'd0, 32'd0);
        serve(-1, -1, -1, 0, 0, 32'h3333_4444, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        int leaks = 0;
        push(b_csr(12'h7B3, 5'd8, 3'b001, 5'd0), 0, 32'd0);
        push(b_lui(5'd8, 20'h12345), 0, 32'd0);
        push(b_lw(5'd8, 5'd8, 12'h678), 0, 32'd0);
        start_cmd(2'd2, 5'd0, 32'h1234_5678, 32'd0);
        serve(-1, -1, 2, 0, 0, 32'd0, 1'b0, 0);
        exp_q.delete();
        @(posedge clk); #1;
        vectors++;
        if (cmd_ready_o !== 1'b1 || insn_valid_o !== 1'b0 || insn_o !== NOP) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got ready %b ival %b insn %h expected 1 0 %h",
                     cmd_ready_o, insn_valid_o, insn_o, NOP);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (insn_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) leaks++;
        end
        vectors++;
        if (leaks != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_cleanup: got %0d active cycles expected 0", leaks);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reg_read();
        test_reg_write();
        test_mem_read();
        test_mem_write_exc();
        test_mem_write_boundary();
        test_mem_read_exc();
        test_ready_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_reg_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
